// File: rtl/sr_piso_tx_pkg.sv
// Shared definitions for the parallel-in serial-out transmitter.
package sr_pkg;

    localparam int   SR_WIDTH_DEFAULT      = 8;
    localparam logic SR_IDLE_LEVEL_DEFAULT = 1'b0;

    // IDLE: line parked at the idle level; SHIFT: a data bit is on q.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } sr_state_e;

endpackage : sr_pkg

// File: rtl/sr_piso_tx_if.sv
// Load handshake and serial output bundle for sr_piso_tx.
interface sr_piso_tx_if
    import sr_pkg::*;
#(
    parameter int WIDTH = SR_WIDTH_DEFAULT
) ();

    logic [WIDTH-1:0] din;
    logic             load_valid;
    logic             load_ready;
    logic             q;
    logic             q_valid;
    logic             q_last;
    logic             busy;

    // Word source: offers din, observes the serial line.
    modport master (
        output din, load_valid,
        input  load_ready, q, q_valid, q_last, busy
    );

    // Transmitter: takes din, drives the serial line.
    modport slave (
        input  din, load_valid,
        output load_ready, q, q_valid, q_last, busy
    );

endinterface : sr_piso_tx_if

// File: rtl/sr_piso_tx_bit_counter.sv
// Bit-position counter: clears to 0, advances on enable, saturates at
// WIDTH-1 and flags that terminal position.
module sr_bit_counter
    import sr_pkg::*;
#(
    parameter int  WIDTH = SR_WIDTH_DEFAULT,
    localparam int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic terminal_o
);

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign terminal_o = (count_q == LAST);

    // Next count: clear wins, otherwise step unless already at the last bit.
    always_comb begin
        // NOTE: count_d is defaulted before any branch so no path leaves it unassigned (no latch).
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && !terminal_o) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule : sr_bit_counter

// File: rtl/sr_piso_tx.sv
// Parallel-in serial-out transmitter. A word is taken over a valid/ready
// handshake and shifted out one bit per clock; the next word can be taken on
// the last bit so consecutive words stream with no idle gap.
module sr_piso_tx
    import sr_pkg::*;
#(
    parameter int   WIDTH      = SR_WIDTH_DEFAULT,
    parameter bit   MSB_FIRST  = 1'b1,
    parameter logic IDLE_LEVEL = SR_IDLE_LEVEL_DEFAULT
) (
    input logic         clk,
    input logic         reset,
    sr_piso_tx_if.slave bus
);

    sr_state_e        state_q;
    logic             q_q;
    logic [WIDTH-2:0] shreg_q;

    logic             q_valid;
    logic             q_last;
    logic             at_last_bit;
    logic             accept;
    logic             first_bit;
    logic             next_bit;
    logic [WIDTH-2:0] load_rest;
    logic [WIDTH-2:0] shift_rest;

    assign q_valid = (state_q == ST_SHIFT);
    assign q_last  = q_valid && at_last_bit;
    assign accept  = bus.load_valid && bus.load_ready;

    assign bus.load_ready = !q_valid || q_last;
    assign bus.q          = q_q;
    assign bus.q_valid    = q_valid;
    assign bus.q_last     = q_last;
    assign bus.busy       = q_valid;

    // Index of the bit on q: restarts on a new word or on leaving SHIFT.
    sr_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (accept || q_last),
        .enable_i   (q_valid && !q_last),
        .terminal_o (at_last_bit)
    );

    // Bit ordering: pick the first bit of din and how the remainder drains.
    always_comb begin
        first_bit  = 1'b0;
        next_bit   = 1'b0;
        load_rest  = '0;
        shift_rest = '0;
        if (MSB_FIRST) begin
            first_bit  = bus.din[WIDTH-1];
            load_rest  = bus.din[WIDTH-2:0];
            next_bit   = shreg_q[WIDTH-2];
            shift_rest = shreg_q << 1;
        end else begin
            first_bit  = bus.din[0];
            load_rest  = bus.din[WIDTH-1:1];
            next_bit   = shreg_q[0];
            shift_rest = shreg_q >> 1;
        end
    end

    // Transmit FSM: load on accept, shift while mid-word, park after last bit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            q_q     <= IDLE_LEVEL;
            shreg_q <= '0;
        end else if (accept) begin
            state_q <= ST_SHIFT;
            q_q     <= first_bit;
            shreg_q <= load_rest;
        end else if (q_valid && !q_last) begin
            q_q     <= next_bit;
            shreg_q <= shift_rest;
        end else if (q_last) begin
            state_q <= ST_IDLE;
            q_q     <= IDLE_LEVEL;
        end
    end

endmodule : sr_piso_tx
